// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-way round-robin arbiter.
package arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // 4:2 encode of a one-hot (or zero) vector; zero maps to index 0.
  function automatic logic [IDX_W-1:0] onehot4_to_idx(input logic [N_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between requesting units and the arbiter.
interface rr_arbiter4_if;
  import arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;

  modport master (output req, input gnt, input gnt_idx, input gnt_valid);
  modport slave  (input req, output gnt, output gnt_idx, output gnt_valid);
endinterface

// File: rtl/rr_pick4.sv
// Combinational rotating-priority pick: first set req bit searching ptr, ptr+1, ... mod 4.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] pick_oh,
  output logic [IDX_W-1:0] pick_idx,
  output logic             pick_any
);

  // Scan from the lowest priority up so the highest-priority hit wins the last write.
  always_comb begin
    pick_oh = '0;
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      if (req[ptr + IDX_W'(k)]) begin
        pick_oh = N_REQ'(1) << (ptr + IDX_W'(k));
      end
    end
  end

  assign pick_any = |req;
  assign pick_idx = onehot4_to_idx(pick_oh);

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter for four requesters with a bounded hold time per grant.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst,
  rr_arbiter4_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(MAX_HOLD) + 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             valid_q, valid_d;

  logic             release_c;
  logic [IDX_W-1:0] search_ptr_c;
  logic [N_REQ-1:0] pick_oh;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  // Owner gives up the slot when it stops asking or has used its full hold window.
  assign release_c    = (state_q == GRANT) && (!bus.req[idx_q] || (hold_q == HOLD_LAST));
  assign search_ptr_c = release_c ? (idx_q + IDX_W'(1)) : ptr_q;

  rr_pick4 u_pick (
    .req      (bus.req),
    .ptr      (search_ptr_c),
    .pick_oh  (pick_oh),
    .pick_idx (pick_idx),
    .pick_any (pick_any)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          gnt_d   = pick_oh;
          idx_d   = pick_idx;
          valid_d = 1'b1;
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (release_c) begin
          // Re-arbitrate in the release cycle so a waiting requester sees no idle bubble.
          ptr_d  = search_ptr_c;
          hold_d = '0;
          if (pick_any) begin
            gnt_d   = pick_oh;
            idx_d   = pick_idx;
            valid_d = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            idx_d   = '0;
            valid_d = 1'b0;
          end
        end else begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        idx_d   = '0;
        valid_d = 1'b0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Scoreboard bench: two arbiters (MAX_HOLD=4 and MAX_HOLD=1) on the same request stream,
// each checked against a behavioural round-robin model.
module tb_rr_arbiter4;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       valid;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rr_arbiter4_if bus4 ();
  rr_arbiter4_if bus1 ();

  rr_arbiter4 #(.MAX_HOLD(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  rr_arbiter4 #(.MAX_HOLD(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  exp_t q4[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   armed    = 1'b0;
  int   cyc      = 0;

  // Model state per arbiter: current owner (-1 = none), cycles already held, search start.
  int m_owner[2] = '{-1, -1};
  int m_held[2]  = '{0, 0};
  int m_start[2] = '{0, 0};
  int m_max[2]   = '{4, 1};

  function automatic int first_req(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_step(input int d, input logic r_rst, input logic [3:0] r, output exp_t e);
    if (r_rst) begin
      m_owner[d] = -1;
      m_held[d]  = 0;
      m_start[d] = 0;
    end else if (m_owner[d] < 0) begin
      m_owner[d] = first_req(r, m_start[d]);
      m_held[d]  = 0;
    end else if (!r[m_owner[d]] || (m_held[d] + 1 >= m_max[d])) begin
      m_start[d] = (m_owner[d] + 1) % 4;
      m_owner[d] = first_req(r, m_start[d]);
      m_held[d]  = 0;
    end else begin
      m_held[d]  = m_held[d] + 1;
    end
    e.valid = (m_owner[d] >= 0);
    e.gnt   = (m_owner[d] >= 0) ? 4'(1 << m_owner[d]) : 4'b0000;
    e.idx   = (m_owner[d] >= 0) ? 2'(m_owner[d]) : 2'd0;
  endtask

  task automatic drive(input logic r_rst, input logic [3:0] r);
    exp_t e;
    @(negedge clk);
    rst      = r_rst;
    bus4.req = r;
    bus1.req = r;
    model_step(0, r_rst, r, e);
    q4.push_back(e);
    model_step(1, r_rst, r, e);
    q1.push_back(e);
    armed = 1'b1;
  endtask

  function automatic logic [1:0] enc(input logic [3:0] g);
    logic [1:0] i;
    i = 2'd0;
    for (int k = 0; k < 4; k++) if (g[k]) i = 2'(k);
    return i;
  endfunction

  task automatic cmp(input string tag, input exp_t e, input logic [3:0] g,
                     input logic [1:0] i, input logic v);
    n_checks++;
    if (g !== e.gnt) begin
      n_fail++;
      $display("FAIL %s gnt cyc=%0d got=%b exp=%b", tag, cyc, g, e.gnt);
    end
    n_checks++;
    if (i !== e.idx) begin
      n_fail++;
      $display("FAIL %s gnt_idx cyc=%0d got=%0d exp=%0d", tag, cyc, i, e.idx);
    end
    n_checks++;
    if (v !== e.valid) begin
      n_fail++;
      $display("FAIL %s gnt_valid cyc=%0d got=%b exp=%b", tag, cyc, v, e.valid);
    end
    n_checks++;
    if (!$onehot0(g) || (v !== (|g)) || (i !== enc(g))) begin
      n_fail++;
      $display("FAIL %s invariant cyc=%0d gnt=%b idx=%0d valid=%b", tag, cyc, g, i, v);
    end
  endtask

  // Monitor: outputs are registered and present a value every cycle.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (armed) begin
      if (q4.size() == 0 || q1.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_empty cyc=%0d q4=%0d q1=%0d required>0", cyc, q4.size(), q1.size());
      end else begin
        cmp("hold4", q4.pop_front(), bus4.gnt, bus4.gnt_idx, bus4.gnt_valid);
        cmp("hold1", q1.pop_front(), bus1.gnt, bus1.gnt_idx, bus1.gnt_valid);
      end
    end
  end

  logic [3:0] rq;

  initial begin
    bus4.req = 4'b0000;
    bus1.req = 4'b0000;

    // Reset with every requester asserted
    drive(1'b1, 4'b1111);
    drive(1'b1, 4'b1111);

    // Single requester raise and drop
    drive(1'b0, 4'b0000);
    repeat (4) drive(1'b0, 4'b0100);
    repeat (2) drive(1'b0, 4'b0000);

    // All requesting: rotation every MAX_HOLD cycles
    drive(1'b1, 4'b0000);
    repeat (20) drive(1'b0, 4'b1111);

    // Solo requester re-granted after each timeout
    drive(1'b1, 4'b0000);
    repeat (12) drive(1'b0, 4'b1000);

    // Owner 1 drops while 0 and 3 wait: next is 3
    drive(1'b1, 4'b0000);
    drive(1'b0, 4'b0010);
    drive(1'b0, 4'b1011);
    repeat (3) drive(1'b0, 4'b1001);

    // Two requesters alternate
    drive(1'b1, 4'b0000);
    repeat (8) drive(1'b0, 4'b0101);

    // Reset while index 2 owns the grant
    drive(1'b1, 4'b0000);
    repeat (2) drive(1'b0, 4'b0100);
    drive(1'b1, 4'b1111);
    repeat (3) drive(1'b0, 4'b1111);

    // Random sticky request traffic with occasional resets
    rq = 4'b0000;
    repeat (400) begin
      if ($urandom_range(0, 2) == 0) rq = rq ^ 4'($urandom);
      drive($urandom_range(0, 59) == 0, rq);
    end

    @(negedge clk);
    armed = 1'b0;
    n_checks++;
    if (q4.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover q4=%0d q1=%0d required=0", q4.size(), q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
